// File: rtl/osd_overlay_scheduler.sv
// osd_overlay_scheduler: round-robin arbiter that hands one overlay request at a
// time to the OSD datapath. Configuration is only committed on a frame rising
// edge, so the datapath never sees a half-updated string mid-frame.
module osd_overlay_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int STRING_LENGTH = 4,
  parameter int CHAR_ENCODING = 8,
  parameter int DATA_WIDTH    = 24,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480,
  parameter int HOLD_FRAMES   = 25,
  localparam int XW  = $clog2(FRAME_W - 2) + 1,
  localparam int YW  = $clog2(FRAME_H - 2) + 1,
  localparam int SW  = STRING_LENGTH * CHAR_ENCODING,
  localparam int CLW = STRING_LENGTH * DATA_WIDTH,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                   pix_clk,
  input  logic                   rstb,
  input  logic                   fval,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*SW-1:0]  req_str,
  input  logic [NUM_REQ*CLW-1:0] req_color,
  input  logic [NUM_REQ*XW-1:0]  req_x,
  input  logic [NUM_REQ*YW-1:0]  req_y,
  output logic [NUM_REQ-1:0]     done,
  output logic [SW-1:0]          str,
  output logic [CLW-1:0]         str_color,
  output logic [XW-1:0]          start_x,
  output logic [YW-1:0]          start_y,
  output logic                   osd_en,
  output logic [IDW-1:0]         active_id,
  output logic                   busy
);

  localparam int CW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, ARM, SHOW, RELEASE} state_t;

  state_t         state, state_nxt;
  logic           fval_d;
  logic           rise, fall;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  frame_cnt, frame_cnt_inc;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic           capture, commit, frame_inc, release_go;
  logic [SW-1:0]  sh_str;
  logic [CLW-1:0] sh_color;
  logic [XW-1:0]  sh_x;
  logic [YW-1:0]  sh_y;

  assign rise          = fval & ~fval_d;
  assign fall          = ~fval & fval_d;
  assign frame_cnt_inc = frame_cnt + 1'b1;
  assign busy          = (state != IDLE);

  // Frame-valid delay; resets high so a reset released mid-frame sees no rise
  always_ff @(posedge pix_clk or posedge rstb) begin
    if (rstb) fval_d <= 1'b1;
    else      fval_d <= fval;
  end

  // Round-robin search starting at rr_ptr; lowest offset wins
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge pix_clk or posedge rstb) begin
    if (rstb) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    commit     = 1'b0;
    frame_inc  = 1'b0;
    release_go = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          capture   = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (!req[active_id]) begin
          state_nxt = IDLE;
        end else if (rise) begin
          commit    = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (fall) begin
          frame_inc = 1'b1;
          if (frame_cnt_inc == CW'(HOLD_FRAMES) || !req[active_id]) begin
            release_go = 1'b1;
            state_nxt  = RELEASE;
          end
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Granted requester and round-robin pointer
  always_ff @(posedge pix_clk or posedge rstb) begin
    if (rstb) begin
      active_id <= '0;
      rr_ptr    <= '0;
    end else begin
      if (capture)           active_id <= grant_id;
      if (state == RELEASE)  rr_ptr    <= IDW'((int'(active_id) + 1) % NUM_REQ);
    end
  end

  // Shadow copy of the granted requester's slices, taken at grant time
  always_ff @(posedge pix_clk) begin
    if (capture) begin
      sh_str   <= req_str[int'(grant_id)*SW +: SW];
      sh_color <= req_color[int'(grant_id)*CLW +: CLW];
      sh_x     <= req_x[int'(grant_id)*XW +: XW];
      sh_y     <= req_y[int'(grant_id)*YW +: YW];
    end
  end

  // Datapath configuration, updated only on the commit after a frame rise
  always_ff @(posedge pix_clk or posedge rstb) begin
    if (rstb) begin
      str       <= '0;
      str_color <= '0;
      start_x   <= '0;
      start_y   <= '0;
    end else if (commit) begin
      str       <= sh_str;
      str_color <= sh_color;
      start_x   <= sh_x;
      start_y   <= sh_y;
    end
  end

  // Overlay enable and hold-frame counter
  always_ff @(posedge pix_clk or posedge rstb) begin
    if (rstb) begin
      osd_en    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (commit) begin
        osd_en    <= 1'b1;
        frame_cnt <= '0;
      end else if (frame_inc) begin
        frame_cnt <= frame_cnt_inc;
      end
      if (release_go) osd_en <= 1'b0;
    end
  end

  // Completion pulse exists only during the single RELEASE cycle
  always_comb begin
    done = '0;
    if (state == RELEASE) done[active_id] = 1'b1;
  end

endmodule

// File: tb/tb_osd_overlay_scheduler.sv
// Directed testbench for osd_overlay_scheduler with HOLD_FRAMES=2.
module tb_osd_overlay_scheduler;

  localparam int NUM_REQ = 4;
  localparam int XW      = 11;
  localparam int YW      = 10;
  localparam int SW      = 32;
  localparam int CLW     = 96;

  logic                   pix_clk = 1'b0;
  logic                   rstb;
  logic                   fval;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*SW-1:0]  req_str;
  logic [NUM_REQ*CLW-1:0] req_color;
  logic [NUM_REQ*XW-1:0]  req_x;
  logic [NUM_REQ*YW-1:0]  req_y;
  logic [NUM_REQ-1:0]     done;
  logic [SW-1:0]          str;
  logic [CLW-1:0]         str_color;
  logic [XW-1:0]          start_x;
  logic [YW-1:0]          start_y;
  logic                   osd_en;
  logic [1:0]             active_id;
  logic                   busy;

  int n_tests = 0;
  int n_fail  = 0;

  osd_overlay_scheduler #(.HOLD_FRAMES(2)) dut (
    .pix_clk(pix_clk), .rstb(rstb), .fval(fval), .req(req),
    .req_str(req_str), .req_color(req_color), .req_x(req_x), .req_y(req_y),
    .done(done), .str(str), .str_color(str_color), .start_x(start_x),
    .start_y(start_y), .osd_en(osd_en), .active_id(active_id), .busy(busy)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] e_str(input int i);
    return 32'h41424344 + 32'(i);
  endfunction
  function automatic logic [CLW-1:0] e_col(input int i);
    return {32'h00AA0000 + 32'(i), 32'h0000BB00 + 32'(i), 32'h000000CC + 32'(i)};
  endfunction
  function automatic logic [XW-1:0] e_x(input int i);
    return XW'(10 + 20 * i);
  endfunction
  function automatic logic [YW-1:0] e_y(input int i);
    return YW'(5 + 7 * i);
  endfunction

  // Every cycle with done high, as seen just after the clock edge
  logic [NUM_REQ-1:0] done_q[$];
  always @(posedge pix_clk) begin
    #1;
    if (done != '0) done_q.push_back(done);
  end

  function automatic logic [NUM_REQ-1:0] q_at(input int k);
    if (done_q.size() > k) return done_q[k];
    return '0;
  endfunction

  // Tear watch: outputs may only change while fval is high on the commit edge
  int   tear_cnt  = 0;
  logic fval_prev = 1'b0;
  logic rst_prev  = 1'b1;
  logic [SW+CLW+XW+YW:0] snap = '0;
  always @(posedge pix_clk) begin : tear_mon
    logic fv;
    logic [SW+CLW+XW+YW:0] cur;
    fv = fval;
    #1;
    cur = {str, str_color, start_x, start_y, osd_en};
    if (!rstb && !rst_prev && fv && fval_prev && cur !== snap) tear_cnt++;
    snap      = cur;
    fval_prev = fv;
    rst_prev  = rstb;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pix_clk);
  endtask

  task automatic frame();
    fval = 1'b1;
    cyc(6);
    fval = 1'b0;
    cyc(4);
  endtask

  task automatic rst_pulse();
    rstb = 1'b1;
    cyc(2);
    rstb = 1'b0;
    cyc(1);
  endtask

  initial begin
    rstb = 1'b1;
    fval = 1'b0;
    req  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_str[i*SW +: SW]    = e_str(i);
      req_color[i*CLW +: CLW] = e_col(i);
      req_x[i*XW +: XW]      = e_x(i);
      req_y[i*YW +: YW]      = e_y(i);
    end
    cyc(3);
    check_eq("rst_osd_en", osd_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_str", str, 0);
    check_eq("rst_start_x", start_x, 0);
    check_eq("rst_active_id", active_id, 0);
    rstb = 1'b0;
    cyc(1);

    // Single request to requester 1
    req = 4'b0010;
    cyc(2);
    check_eq("s1_busy", busy, 1);
    check_eq("s1_active_id", active_id, 1);
    check_eq("s1_pre_osd_en", osd_en, 0);
    check_eq("s1_pre_str", str, 0);
    fval = 1'b1;
    cyc(1);
    check_eq("s1_osd_en", osd_en, 1);
    check_eq("s1_str", str, e_str(1));
    check_eq("s1_color", str_color, e_col(1));
    check_eq("s1_x", start_x, e_x(1));
    check_eq("s1_y", start_y, e_y(1));
    cyc(5);
    fval = 1'b0;
    cyc(4);
    check_eq("s1_after_f1", osd_en, 1);
    check_eq("s1_no_done_yet", done_q.size(), 0);
    fval = 1'b1;
    cyc(6);
    fval = 1'b0;
    cyc(1);
    check_eq("s1_release_osd_en", osd_en, 0);
    check_eq("s1_done", done, 4'b0010);
    req = '0;
    cyc(1);
    check_eq("s1_done_clear", done, 0);
    check_eq("s1_idle", busy, 0);
    check_eq("s1_str_hold", str, e_str(1));
    check_eq("s1_done_count", done_q.size(), 1);
    cyc(2);

    // Round robin with 0,1,3 requesting
    rst_pulse();
    done_q.delete();
    req = 4'b1011;
    for (int f = 0; f < 12 && done_q.size() < 4; f++) frame();
    req = '0;
    cyc(3);
    check_eq("rr_count", done_q.size(), 4);
    check_eq("rr_0", q_at(0), 4'b0001);
    check_eq("rr_1", q_at(1), 4'b0010);
    check_eq("rr_2", q_at(2), 4'b1000);
    check_eq("rr_3", q_at(3), 4'b0001);

    // Withdrawal in SHOW then in ARM
    rst_pulse();
    done_q.delete();
    req = 4'b0100;
    cyc(2);
    fval = 1'b1;
    cyc(3);
    check_eq("wd_on", osd_en, 1);
    check_eq("wd_str", str, e_str(2));
    req = '0;
    cyc(3);
    check_eq("wd_hold_in_frame", osd_en, 1);
    fval = 1'b0;
    cyc(1);
    check_eq("wd_off", osd_en, 0);
    check_eq("wd_done", done, 4'b0100);
    cyc(3);
    req = 4'b0001;
    cyc(2);
    check_eq("wa_busy", busy, 1);
    check_eq("wa_active_id", active_id, 0);
    req = '0;
    cyc(2);
    check_eq("wa_idle", busy, 0);
    frame();
    check_eq("wa_osd_en", osd_en, 0);
    check_eq("wa_str", str, e_str(2));
    check_eq("wa_x", start_x, e_x(2));
    check_eq("wa_no_done", done_q.size(), 1);

    // Reset pulsed mid-frame while an overlay is showing
    req = 4'b0001;
    cyc(2);
    fval = 1'b1;
    cyc(2);
    check_eq("mr_on", osd_en, 1);
    rstb = 1'b1;
    #1;
    check_eq("mr_async_clear", osd_en, 0);
    cyc(2);
    rstb = 1'b0;
    cyc(3);
    check_eq("mr_no_commit", osd_en, 0);
    check_eq("mr_str_zero", str, 0);
    check_eq("mr_armed", busy, 1);
    fval = 1'b0;
    cyc(4);
    check_eq("mr_no_done", done_q.size(), 1);
    fval = 1'b1;
    cyc(1);
    check_eq("mr_commit", osd_en, 1);
    check_eq("mr_str", str, e_str(0));
    req = '0;
    cyc(5);
    fval = 1'b0;
    cyc(1);
    check_eq("mr_done", done, 4'b0001);
    cyc(3);

    // Input slice changes after grant must not reach the outputs
    rst_pulse();
    done_q.delete();
    req = 4'b0001;
    cyc(2);
    req_x[0 +: XW] = 11'd200;
    fval = 1'b1;
    cyc(1);
    check_eq("ic_commit_x", start_x, 10);
    cyc(5);
    fval = 1'b0;
    cyc(4);
    check_eq("ic_f1_x", start_x, 10);
    fval = 1'b1;
    cyc(3);
    check_eq("ic_f2_x", start_x, 10);
    check_eq("ic_f2_on", osd_en, 1);
    req = '0;
    cyc(3);
    fval = 1'b0;
    cyc(1);
    check_eq("ic_done", done, 4'b0001);
    check_eq("ic_off", osd_en, 0);
    cyc(3);
    check_eq("ic_single_done", done_q.size(), 1);
    check_eq("ic_hold_x", start_x, 10);

    check_eq("tear", tear_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
